// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_pkg;

    typedef enum logic [2:0] {IDLE, SPAWN, UP, HIT, MISS, OVER} state_t;

    localparam logic [4:0]  KEY_NONE     = 5'd16;
    // Active-low column drives, four bits per column, column 0 in the low nibble.
    localparam logic [15:0] COL_PATTERNS = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [1:0]  MAX_LEVEL    = 2'd3;

endpackage

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with frame decode, frame-count debounce and a
// one-shot press event on the NONE -> key transition of the debounced code.
module keypad_scan_debounce
    import mole_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] key_code,
    output logic       press_evt
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEB_FRAMES + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       cidx_q, cidx_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [3:0]       fcode_q, fcode_d;
    logic [4:0]       cand_q, cand_d;
    logic [4:0]       deb_q, deb_d;
    logic [DEB_W-1:0] stab_q, stab_d;
    logic             evt_q, evt_d;
    logic [1:0]       slot_cnt;
    logic [3:0]       slot_code;
    logic [4:0]       frame_code;

    always_comb begin
        div_d      = div_q;
        cidx_d     = cidx_q;
        fcnt_d     = fcnt_q;
        fcode_d    = fcode_q;
        cand_d     = cand_q;
        deb_d      = deb_q;
        stab_d     = stab_q;
        evt_d      = 1'b0;
        slot_cnt   = fcnt_q;
        slot_code  = fcode_q;
        frame_code = KEY_NONE;

        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d  = '0;
            cidx_d = cidx_q + 2'd1;
            // Key count saturates at 2: anything above one key is the same "invalid".
            for (int r = 0; r < 4; r++) begin
                if (!row[r]) begin
                    if (slot_cnt != 2'd2) slot_cnt = slot_cnt + 2'd1;
                    slot_code = {2'(r), cidx_q};
                end
            end
            if (cidx_q == 2'd3) begin
                frame_code = (slot_cnt == 2'd1) ? {1'b0, slot_code} : KEY_NONE;
                fcnt_d     = '0;
                fcode_d    = '0;
                if (frame_code == cand_q) begin
                    if (stab_q != DEB_W'(DEB_FRAMES)) stab_d = stab_q + DEB_W'(1);
                end else begin
                    cand_d = frame_code;
                    stab_d = DEB_W'(1);
                end
                if (stab_d == DEB_W'(DEB_FRAMES)) deb_d = cand_d;
                evt_d = (deb_q == KEY_NONE) && (deb_d != KEY_NONE);
            end else begin
                fcnt_d  = slot_cnt;
                fcode_d = slot_code;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            cidx_q  <= '0;
            fcnt_q  <= '0;
            fcode_q <= '0;
            cand_q  <= KEY_NONE;
            deb_q   <= KEY_NONE;
            stab_q  <= '0;
            evt_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            cidx_q  <= cidx_d;
            fcnt_q  <= fcnt_d;
            fcode_q <= fcode_d;
            cand_q  <= cand_d;
            deb_q   <= deb_d;
            stab_q  <= stab_d;
            evt_q   <= evt_d;
        end
    end

    assign col       = COL_PATTERNS[{cidx_q, 2'b00} +: 4];
    assign key_code  = deb_q;
    assign press_evt = evt_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: LFSR mole selection, per-level mole window,
// hit/miss scoring with lives, buzzer and game-over blink.
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int N_MOLES        = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int DEB_FRAMES     = 5,
    parameter int BASE_INTERVAL  = 200000000,
    parameter int HITS_PER_LEVEL = 10,
    parameter int LIVES          = 3,
    parameter int GAP_CYCLES     = 50000000,
    parameter int BEEP_CYCLES    = 10000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         row,
    output logic [3:0]         col,
    output logic [N_MOLES-1:0] led,
    output logic               buzzer,
    output logic [15:0]        score,
    output logic [1:0]         level,
    output logic [2:0]         lives,
    output logic               game_over
);

    localparam int MOLE_W = $clog2(N_MOLES);
    localparam int HIT_W  = $clog2(HITS_PER_LEVEL + 1);

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [MOLE_W-1:0] mole_q, mole_d;
    logic [31:0]       window_q, window_d;
    logic [31:0]       gap_q, gap_d;
    logic [15:0]       score_q, score_d;
    logic [1:0]        level_q, level_d;
    logic [2:0]        lives_q, lives_d;
    logic [HIT_W-1:0]  hitc_q, hitc_d;
    logic              blink_q, blink_d;

    logic [4:0]        key_code;
    logic              press_evt;
    logic [MOLE_W-1:0] cand;
    logic              hit_key;
    logic              miss_key;
    logic              do_init;

    keypad_scan_debounce #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_FRAMES(DEB_FRAMES)
    ) u_kp (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .press_evt(press_evt)
    );

    assign cand     = lfsr_q[MOLE_W-1:0];
    assign hit_key  = press_evt && (key_code == 5'(mole_q));
    assign miss_key = press_evt && (key_code < 5'(N_MOLES)) && !hit_key;
    assign do_init  = start && ((state_q == IDLE) || (state_q == OVER));

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        mole_d    = mole_q;
        window_d  = window_q;
        gap_d     = gap_q;
        score_d   = score_q;
        level_d   = level_q;
        lives_d   = lives_q;
        hitc_d    = hitc_q;
        blink_d   = blink_q;
        led       = '0;
        buzzer    = 1'b0;
        game_over = 1'b0;

        case (state_q)
            SPAWN: begin
                // Never repeat the previous mole; the +1 wraps since N_MOLES is a power of two.
                mole_d   = (cand == mole_q) ? cand + MOLE_W'(1) : cand;
                window_d = 32'(BASE_INTERVAL) >> level_q;
                state_d  = UP;
            end
            UP: begin
                led      = N_MOLES'(1) << mole_q;
                window_d = window_q - 32'd1;
                if (hit_key) begin
                    state_d = HIT;
                    gap_d   = '0;
                    score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                    if (hitc_q >= HIT_W'(HITS_PER_LEVEL - 1)) begin
                        if (level_q < MAX_LEVEL) begin
                            level_d = level_q + 2'd1;
                            hitc_d  = '0;
                        end else begin
                            hitc_d  = HIT_W'(HITS_PER_LEVEL);
                        end
                    end else begin
                        hitc_d = hitc_q + HIT_W'(1);
                    end
                end else if (miss_key || (window_q <= 32'd1)) begin
                    state_d = MISS;
                    gap_d   = '0;
                    lives_d = lives_q - 3'd1;
                end
            end
            HIT: begin
                buzzer = (gap_q < 32'(BEEP_CYCLES));
                gap_d  = gap_q + 32'd1;
                if (gap_q == 32'(GAP_CYCLES - 1)) state_d = SPAWN;
            end
            MISS: begin
                if (lives_q == 3'd0) begin
                    state_d = OVER;
                    gap_d   = '0;
                    blink_d = 1'b1;
                end else begin
                    buzzer = 1'b1;
                    gap_d  = gap_q + 32'd1;
                    if (gap_q == 32'(GAP_CYCLES - 1)) state_d = SPAWN;
                end
            end
            OVER: begin
                game_over = 1'b1;
                led       = blink_q ? '1 : '0;
                gap_d     = gap_q + 32'd1;
                if (gap_q == 32'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    blink_d = ~blink_q;
                end
            end
            default: ;
        endcase

        if (do_init) begin
            score_d = '0;
            level_d = '0;
            lives_d = 3'(LIVES);
            hitc_d  = '0;
            state_d = SPAWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            mole_q   <= '0;
            window_q <= '0;
            gap_q    <= '0;
            score_q  <= '0;
            level_q  <= '0;
            lives_q  <= 3'(LIVES);
            hitc_q   <= '0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            mole_q   <= mole_d;
            window_q <= window_d;
            gap_q    <= gap_d;
            score_q  <= score_d;
            level_q  <= level_d;
            lives_q  <= lives_d;
            hitc_q   <= hitc_d;
            blink_q  <= blink_d;
        end
    end

    assign score = score_q;
    assign level = level_q;
    assign lives = lives_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: keypad debounce, hits, misses, levels,
// game over blink, restart and asynchronous reset.
module tb_mole_game_ctrl;

    localparam int N_MOLES = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [7:0]  led;
    logic        buzzer;
    logic [15:0] score;
    logic [1:0]  level;
    logic [2:0]  lives;
    logic        game_over;

    logic [15:0] key_mask = '0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    mole_game_ctrl #(
        .N_MOLES(8), .SCAN_DIV(4), .DEB_FRAMES(2), .BASE_INTERVAL(256),
        .HITS_PER_LEVEL(2), .LIVES(3), .GAP_CYCLES(16), .BEEP_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row(row), .col(col),
        .led(led), .buzzer(buzzer), .score(score), .level(level),
        .lives(lives), .game_over(game_over)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int onehot_idx(input logic [7:0] v);
        int idx = 0;
        for (int i = 0; i < N_MOLES; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    task automatic wait_led_on(input string tag);
        int n = 0;
        while (led == '0 && n < 1000) begin tick(); n++; end
        check(tag, 32'(n < 1000), 1);
    endtask

    task automatic wait_led_off(input string tag);
        int n = 0;
        while (led != '0 && n < 1000) begin tick(); n++; end
        check(tag, 32'(n < 1000), 1);
    endtask

    task automatic wait_none();
        int n = 0;
        while (dut.u_kp.key_code != 5'd16 && n < 1000) begin tick(); n++; end
        check("key_none_timeout", 32'(n < 1000), 1);
    endtask

    task automatic wait_evt(input string tag);
        int n = 0;
        while (!dut.u_kp.press_evt && n < 1000) begin tick(); n++; end
        check(tag, 32'(n < 1000), 1);
    endtask

    task automatic count_led(input logic [7:0] val, output int n);
        n = 0;
        while (led === val && n < 1000) begin n++; tick(); end
    endtask

    // Counts LED-off cycles and buzzer-high cycles within them.
    task automatic measure_gap(output int b, output int o);
        b = 0;
        o = 0;
        while (led == '0 && o < 1000) begin
            o++;
            if (buzzer) b++;
            tick();
        end
    endtask

    task automatic hit_round(output int m, output int b, output int o);
        wait_led_on("hit_led_on");
        m = onehot_idx(led);
        wait_none();
        key_mask = 16'(1) << m;
        wait_led_off("hit_led_off");
        key_mask = '0;
        measure_gap(b, o);
    endtask

    initial begin
        int evts;
        int code;
        int m0, m1, m;
        int b, o, n;
        logic [7:0] on_val;

        // Reset state
        tick(); tick(); tick();
        check("rst_col", 32'(col), 32'h0E);
        check("rst_led", 32'(led), 0);
        check("rst_buzzer", 32'(buzzer), 0);
        check("rst_score", 32'(score), 0);
        check("rst_level", 32'(level), 0);
        check("rst_lives", 32'(lives), 3);
        check("rst_game_over", 32'(game_over), 0);
        rst_n = 1'b1;

        // Key 5 held for three frames then released: exactly one event, code 5
        evts = 0;
        code = 0;
        key_mask = 16'(1) << 5;
        for (int i = 0; i < 112; i++) begin
            if (i == 48) key_mask = '0;
            if (dut.u_kp.press_evt) begin evts++; code = int'(dut.u_kp.key_code); end
            tick();
        end
        check("key5_event_count", 32'(evts), 1);
        check("key5_event_code", 32'(code), 5);
        wait_none();

        // Two keys at once: never a valid frame, so no event
        evts = 0;
        key_mask = (16'(1) << 5) | (16'(1) << 6);
        for (int i = 0; i < 112; i++) begin
            if (i == 64) key_mask = '0;
            if (dut.u_kp.press_evt) evts++;
            tick();
        end
        check("two_key_event_count", 32'(evts), 0);
        check("idle_led", 32'(led), 0);

        // Start game; key 12 is out of range and must change nothing
        start = 1'b1; tick(); start = 1'b0;
        wait_led_on("first_led_on");
        check("first_onehot", 32'($countones(led)), 1);
        m0 = onehot_idx(led);
        on_val = led;
        key_mask = 16'(1) << 12;
        wait_evt("key12_evt");
        check("key12_code", 32'(dut.u_kp.key_code), 12);
        key_mask = '0;
        tick();
        check("key12_led_kept", 32'(led), 32'(on_val));
        check("key12_lives", 32'(lives), 3);
        check("key12_score", 32'(score), 0);

        // Hit 1
        hit_round(m, b, o);
        check("hit1_mole", 32'(m), 32'(m0));
        check("hit1_score", 32'(score), 1);
        check("hit1_buzz_cycles", 32'(b), 8);
        check("hit1_led_off_16_or_17", 32'(o >= 16 && o <= 17), 1);
        check("hit1_new_onehot", 32'($countones(led)), 1);
        m1 = onehot_idx(led);
        check("hit1_new_mole_differs", 32'(m1 != m0), 1);

        // Hit 2 -> level 1
        hit_round(m, b, o);
        check("hit2_score", 32'(score), 2);
        check("hit2_level", 32'(level), 1);

        // Timeout at level 1: window 128, miss costs a life, buzzer for the whole gap
        wait_led_on("to1_led_on");
        count_led(led, n);
        check("to1_window", 32'(n), 128);
        measure_gap(b, o);
        check("to1_lives", 32'(lives), 2);
        check("to1_buzz_cycles", 32'(b), 16);
        check("to1_level", 32'(level), 1);

        // Wrong in-range key -> miss
        wait_led_on("wrong_led_on");
        m = onehot_idx(led);
        wait_none();
        key_mask = 16'(1) << ((m + 1) % N_MOLES);
        wait_led_off("wrong_led_off");
        key_mask = '0;
        measure_gap(b, o);
        check("wrong_lives", 32'(lives), 1);
        check("wrong_buzz_cycles", 32'(b), 16);
        check("wrong_score", 32'(score), 2);

        // Four more hits -> level 2 then level 3
        hit_round(m, b, o);
        hit_round(m, b, o);
        check("hit4_level", 32'(level), 2);
        hit_round(m, b, o);
        hit_round(m, b, o);
        check("hit6_level", 32'(level), 3);
        check("hit6_score", 32'(score), 6);

        // Timeout at level 3: window 32, last life lost -> game over
        wait_led_on("to3_led_on");
        count_led(led, n);
        check("to3_window", 32'(n), 32);
        n = 0;
        while (!game_over && n < 100) begin tick(); n++; end
        check("over_reached", 32'(n < 100), 1);
        check("over_buzzer", 32'(buzzer), 0);
        count_led(8'hFF, n);
        check("over_blink_on", 32'(n), 16);
        count_led(8'h00, n);
        check("over_blink_off", 32'(n), 16);
        check("over_level", 32'(level), 3);
        check("over_lives", 32'(lives), 0);
        check("over_score", 32'(score), 6);

        // Restart from game over
        start = 1'b1; tick(); start = 1'b0;
        check("restart_score", 32'(score), 0);
        check("restart_lives", 32'(lives), 3);
        check("restart_level", 32'(level), 0);
        check("restart_game_over", 32'(game_over), 0);
        hit_round(m, b, o);
        check("restart_hit_score", 32'(score), 1);
        wait_led_on("to0_led_on");
        count_led(led, n);
        check("to0_window", 32'(n), 256);
        measure_gap(b, o);
        check("to0_lives", 32'(lives), 2);

        // Asynchronous reset in the middle of UP
        wait_led_on("arst_led_on");
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_led", 32'(led), 0);
        check("arst_buzzer", 32'(buzzer), 0);
        check("arst_col", 32'(col), 32'h0E);
        check("arst_score", 32'(score), 0);
        check("arst_lives", 32'(lives), 3);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (led != '0) n++;
            tick();
        end
        check("arst_idle_led_dark", 32'(n), 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_led_on("arst_resume_led_on");
        check("arst_resume_onehot", 32'($countones(led)), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
